// File: rtl/main_control_fsm_pkg.sv
// Shared control definitions: FSM state encoding, opcode and ALU-op
// constants, operand-select codes and the control-word bundle.
package main_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ILLEGAL  = 4'd10
  } state_t;

  localparam logic [2:0] OP_R      = 3'b000;
  localparam logic [2:0] OP_I      = 3'b001;
  localparam logic [2:0] OP_LOAD   = 3'b010;
  localparam logic [2:0] OP_STORE  = 3'b011;
  localparam logic [2:0] OP_BRANCH = 3'b100;

  localparam logic [1:0] S_T = 2'b00;
  localparam logic [1:0] B_T = 2'b01;
  localparam logic [1:0] R_T = 2'b10;
  localparam logic [1:0] I_T = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_INC   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/main_control_fsm_decoder.sv
// State-to-control-word decode for the multicycle control FSM.
// Strobes are forced low while reset is held.
module control_output_decoder
  import main_control_fsm_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   reset,
  output ctrl_t  ctrl
);

  // per-state control word, then strobe masking during reset
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.adr_src    = 1'b0;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_INC;
        ctrl.alu_op     = S_T;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = S_T;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = S_T;
      end
      S_MEMREAD: begin
        ctrl.adr_src  = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = R_T;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = I_T;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_RS2;
        ctrl.alu_op     = B_T;
        ctrl.branch     = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_ILLEGAL: begin
        ctrl.illegal = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if (reset) begin
      ctrl.pc_write  = 1'b0;
      ctrl.ir_write  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.reg_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.illegal   = 1'b0;
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control FSM for the 16-bit core: state register,
// next-state logic and the control-word decoder instance.
module main_control_fsm
  import main_control_fsm_pkg::*;
#(
  parameter int unsigned PC_INC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       illegal,
  output logic [3:0] state
);

  // PC advances by whole 16-bit instructions
  if (PC_INC == 0 || (PC_INC % 2) != 0) begin : g_pc_inc_chk
    $error("PC_INC must be a non-zero even byte count");
  end

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // state register; reset wins over any wait or in-flight access
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE:
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEMADR;
          OP_BRANCH:          state_d = S_BRANCH;
          default:            state_d = S_ILLEGAL;
        endcase
      S_MEMADR:
        if (!is_mem_op(opcode))     state_d = S_FETCH;
        else if (opcode == OP_LOAD) state_d = S_MEMREAD;
        else                        state_d = S_MEMWRITE;
      S_MEMREAD:
        if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:
        state_d = S_FETCH;
      S_MEMWRITE:
        if (mem_ready) state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I:
        state_d = S_ALUWB;
      S_ALUWB, S_BRANCH, S_ILLEGAL:
        state_d = S_FETCH;
      default:
        state_d = S_FETCH;
    endcase
  end

  control_output_decoder u_dec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .reset     (reset),
    .ctrl      (ctrl)
  );

  assign pc_write   = ctrl.pc_write;
  assign branch     = ctrl.branch;
  assign ir_write   = ctrl.ir_write;
  assign adr_src    = ctrl.adr_src;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  assign illegal    = ctrl.illegal;
  assign state      = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: per-instruction expected state traces
// built from the instruction class, with random memory wait cycles.
module tb_main_control_fsm;
  import main_control_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic       mem_ready = 1'b0;
  logic       pc_write, branch, ir_write, adr_src;
  logic       mem_read, mem_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_control_fsm #(.PC_INC(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .branch     (branch),
    .ir_write   (ir_write),
    .adr_src    (adr_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .illegal    (illegal),
    .state      (state)
  );

  // expected control word for a named phase, straight from the state table
  function automatic ctrl_t exp_outs(input state_t s, input logic mr,
                                     input logic rst);
    ctrl_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.mem_read = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
        o.ir_write = mr;   o.pc_write = mr;
      end
      S_DECODE:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
      S_MEMADR:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
      S_MEMREAD:  begin o.adr_src = 1'b1; o.mem_read = 1'b1; end
      S_MEMWB:    begin o.reg_write = 1'b1; o.result_src = 2'b01; end
      S_MEMWRITE: begin o.adr_src = 1'b1; o.mem_write = 1'b1; end
      S_EXEC_R:   begin o.alu_src_a = 2'b10; o.alu_op = 2'b10; end
      S_EXEC_I: begin
        o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_op = 2'b11;
      end
      S_ALUWB:    o.reg_write = 1'b1;
      S_BRANCH: begin
        o.alu_src_a = 2'b10; o.alu_op = 2'b01; o.branch = 1'b1;
      end
      S_ILLEGAL:  o.illegal = 1'b1;
      default:    o = '0;
    endcase
    if (rst) begin
      o.pc_write = 1'b0; o.ir_write = 1'b0; o.mem_write = 1'b0;
      o.reg_write = 1'b0; o.branch = 1'b0; o.illegal = 1'b0;
    end
    return o;
  endfunction

  // one clock: drive inputs on the falling edge, check 1ns later
  task automatic cyc(input state_t es, input logic [2:0] op,
                     input logic mr, input logic rst);
    ctrl_t got;
    ctrl_t exp;
    @(negedge clk);
    opcode = op;
    mem_ready = mr;
    reset = rst;
    #1;
    got = '{pc_write, branch, ir_write, adr_src, mem_read, mem_write,
            reg_write, alu_src_a, alu_src_b, alu_op, result_src, illegal};
    exp = exp_outs(es, mr, rst);
    checks++;
    assert (state === 4'(es)) else begin
      errors++;
      $error("FAIL state got %0d expected %0d", state, 4'(es));
    end
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL outputs st=%0d got %h expected %h", 4'(es), got, exp);
    end
    checks++;
    assert (!(mem_read && mem_write) && !(reg_write && mem_write)) else begin
      errors++;
      $error("FAIL exclusion rd=%b wr=%b rw=%b required no overlap",
             mem_read, mem_write, reg_write);
    end
  endtask

  // full instruction: fetch waits fw, data access waits mw
  task automatic run_instr(input logic [2:0] op, input int fw, input int mw);
    for (int i = 0; i <= fw; i++) cyc(S_FETCH, op, i == fw, 1'b0);
    cyc(S_DECODE, op, 1'($urandom), 1'b0);
    case (op)
      3'b000: begin
        cyc(S_EXEC_R, op, 1'($urandom), 1'b0);
        cyc(S_ALUWB, op, 1'($urandom), 1'b0);
      end
      3'b001: begin
        cyc(S_EXEC_I, op, 1'($urandom), 1'b0);
        cyc(S_ALUWB, op, 1'($urandom), 1'b0);
      end
      3'b010: begin
        cyc(S_MEMADR, op, 1'($urandom), 1'b0);
        for (int i = 0; i <= mw; i++) cyc(S_MEMREAD, op, i == mw, 1'b0);
        cyc(S_MEMWB, op, 1'($urandom), 1'b0);
      end
      3'b011: begin
        cyc(S_MEMADR, op, 1'($urandom), 1'b0);
        for (int i = 0; i <= mw; i++) cyc(S_MEMWRITE, op, i == mw, 1'b0);
      end
      3'b100: cyc(S_BRANCH, op, 1'($urandom), 1'b0);
      default: cyc(S_ILLEGAL, op, 1'($urandom), 1'b0);
    endcase
  endtask

  initial begin
    @(posedge clk);
    cyc(S_FETCH, 3'b000, 1'b1, 1'b1);
    cyc(S_FETCH, 3'b000, 1'b0, 1'b1);
    cyc(S_FETCH, 3'b101, 1'b1, 1'b1);

    run_instr(3'b000, 0, 0);
    run_instr(3'b010, 0, 3);
    run_instr(3'b011, 0, 0);
    run_instr(3'b011, 1, 2);
    run_instr(3'b100, 0, 0);
    run_instr(3'b110, 0, 0);
    run_instr(3'b001, 2, 0);

    cyc(S_FETCH, 3'b011, 1'b1, 1'b0);
    cyc(S_DECODE, 3'b011, 1'b1, 1'b0);
    cyc(S_MEMADR, 3'b011, 1'b1, 1'b0);
    cyc(S_MEMWRITE, 3'b011, 1'b0, 1'b0);
    cyc(S_MEMWRITE, 3'b011, 1'b0, 1'b1);
    cyc(S_FETCH, 3'b011, 1'b1, 1'b1);
    cyc(S_FETCH, 3'b011, 1'b0, 1'b1);

    for (int n = 0; n < 150; n++)
      run_instr(3'($urandom_range(0, 7)), $urandom_range(0, 2),
                $urandom_range(0, 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
